// File: rtl/dmem_store_buffer.sv
// Store buffer between the single-cycle datapath and a slower data memory.
// Stores are absorbed into a circular FIFO and drained in order; loads forward from the youngest match.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_write,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          write_data,
  output logic [DATA_W-1:0]          read_data,
  output logic                       stall,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [DATA_W-1:0]          mem_rd_data,
  output logic                       mem_wr_valid,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  input  logic                       mem_wr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A store seen while full is refused even if the head drains this same cycle,
  // so stall never depends on mem_wr_ready.
  assign stall = mem_write & full;
  assign push  = mem_write & ~full;

  // Write port handshake: mem_wr_valid/addr/data hold steady until the cycle
  // mem_wr_ready is high with mem_wr_valid; the entry retires on that clk edge.
  assign mem_wr_valid = ~empty;
  assign mem_wr_addr  = addr_q[head_q];
  assign mem_wr_data  = data_q[head_q];
  assign pop          = mem_wr_valid & mem_wr_ready;

  assign mem_rd_addr = addr;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      addr_q[tail_q] <= addr;
      data_q[tail_q] <= write_data;
    end
  end

  // Scan oldest to youngest so the last valid match wins; the popping head
  // entry is still counted, a store pushed this cycle is not yet stored.
  always_comb begin
    logic [PTR_W-1:0] idx;
    read_data = mem_rd_data;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx][ADDR_W-1:2] == addr[ADDR_W-1:2]))
        read_data = data_q[idx];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomised plus directed bench for dmem_store_buffer; a queue-based reference
// model predicts every output and the drained write sequence.
module tb_dmem_store_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              stall;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic [CNT_W-1:0]  count;
  logic              empty;

  dmem_store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_write    (mem_write),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .stall        (stall),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .count        (count),
    .empty        (empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  bit   model_init = 1'b0;
  logic exp_full;
  logic [DATA_W-1:0] exp_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor + reference model ----------------
  // Inputs change just after posedge, so at negedge they hold the values the next edge sees.
  always @(negedge clk) begin
    exp_full = (exp_q.size() == DEPTH);
    if (model_init) begin
      chk("stall", stall, mem_write && exp_full);
      chk("count", count, exp_q.size());
      chk("empty", empty, exp_q.size() == 0);
      chk("wr_valid", mem_wr_valid, exp_q.size() != 0);
      chk("rd_addr", mem_rd_addr, addr);
      exp_rd = mem_rd_data;
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i][ADDR_W+DATA_W-1:DATA_W+2] == addr[ADDR_W-1:2])
          exp_rd = exp_q[i][DATA_W-1:0];
      chk("read_data", read_data, exp_rd);
      if (exp_q.size() != 0) begin
        chk("wr_addr", mem_wr_addr, exp_q[0][ADDR_W+DATA_W-1:DATA_W]);
        chk("wr_data", mem_wr_data, exp_q[0][DATA_W-1:0]);
      end
    end
    if (!rst) begin
      exp_q.delete();
      model_init = 1'b1;
    end else if (model_init) begin
      if (exp_q.size() != 0 && mem_wr_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (mem_write && !exp_full) exp_q.push_back({addr, write_data});
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic rs, input logic we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic rdy);
    rst          = rs;
    mem_write    = we;
    addr         = a;
    write_data   = d;
    mem_wr_ready = rdy;
    mem_rd_data  = $urandom;
    @(posedge clk);
    #1;
  endtask

  int pops_before;

  initial begin
    rst = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    mem_wr_ready = 1'b0; mem_rd_data = '0;
    #1;
    // reset, then idle
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(1, 0, 32'h100, 0, 0);
    cyc(1, 0, 32'h104, 0, 0);

    // single store drained with zero wait states
    cyc(1, 1, 32'h100, 32'hAAAA0001, 1);
    cyc(1, 0, 32'h100, 0, 1);
    cyc(1, 0, 32'h0, 0, 1);

    // youngest-match forwarding, byte bits ignored
    cyc(1, 1, 32'h10, 32'd1, 0);
    cyc(1, 1, 32'h14, 32'd2, 0);
    cyc(1, 1, 32'h10, 32'd3, 0);
    cyc(1, 0, 32'h12, 0, 0);
    cyc(1, 0, 32'h18, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h12, 0, 1);

    // fill, stall, stall with pop, accept; pointers wrap
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h200 + 32'(4*i), 32'hB0 + 32'(i), 0);
    cyc(1, 1, 32'h300, 32'hC5, 0);
    cyc(1, 1, 32'h300, 32'hC5, 1);
    cyc(1, 1, 32'h300, 32'hC5, 0);
    cyc(1, 0, 32'h300, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h204, 0, 1);

    // steady push with ready high
    pops_before = pops;
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'h400 + 32'(4*i), 32'(i), 1);
    cyc(1, 0, 32'h0, 0, 1);
    cyc(1, 0, 32'h0, 0, 1);
    chk("steady_pops", pops - pops_before, 10);

    // reset mid-drain discards buffered stores
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h500 + 32'(4*i), 32'hD0 + 32'(i), 0);
    cyc(0, 0, 32'h504, 0, 0);
    cyc(1, 0, 32'h504, 0, 0);
    cyc(1, 0, 32'h500, 0, 1);

    // randomised traffic over a small address window
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
          1'($urandom_range(0, 99) < 60),
          32'h40 + 32'($urandom_range(0, 31)),
          $urandom,
          1'($urandom_range(0, 99) < 45));
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 0, 32'h0, 0, 1);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the single-cycle datapath, between its data-memory side (alu_result, write_data, mem_write, read_data) and a slower backing data memory.
- Absorbs each store in one cycle into a small circular FIFO, then drains the stores to memory over a valid/ready write port.
- Serves loads combinationally, forwarding the newest matching buffered store, otherwise passing through backing-memory read data.
- Asserts stall only when a store arrives while the FIFO is full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width; word index is addr[ADDR_W-1:2].

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- mem_write  in  1  core store request this cycle
- addr  in  ADDR_W  core byte address (datapath alu_result)
- write_data  in  DATA_W  core store data
- read_data  out  DATA_W  load data returned to core
- stall  out  1  core must hold the PC and retry the store
- mem_rd_addr  out  ADDR_W  backing memory read address
- mem_rd_data  in  DATA_W  backing memory combinational read data
- mem_wr_valid  out  1  head store presented to memory
- mem_wr_addr  out  ADDR_W  head store address
- mem_wr_data  out  DATA_W  head store data
- mem_wr_ready  in  1  memory accepts head store
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count==0

Behaviour:
- Reset: when rst==0 at a clk edge, head=0, tail=0, count=0.
  - Consequently mem_wr_valid=0, empty=1 and stall=0 in the following cycle.
  - Entry contents are don't-care.
  - Reset mid-drain discards all buffered stores. No handshake completes on a reset edge.
- Full: full = (count==DEPTH).
- Stall: stall = mem_write & full, purely combinational.
  - A store seen while full is not accepted, even if a pop occurs in the same cycle.
  - The core re-presents the store next cycle.
- Push: mem_write & ~full writes {addr, write_data} at tail on the clk edge; tail increments modulo DEPTH.
- Pop:
  - mem_wr_valid = ~empty; mem_wr_addr and mem_wr_data come from the head entry.
  - Pop occurs on mem_wr_valid & mem_wr_ready; head increments modulo DEPTH.
  - Head entry and mem_wr_valid remain stable until accepted.
- Count update:
  - Push and pop in the same cycle leave count unchanged.
  - Push only: count+1. Pop only: count-1.
  - Overflow and underflow are impossible by construction.
- Ordering: stores drain strictly in push order.
- Load path:
  - mem_rd_addr = addr, always.
  - read_data = data of the youngest valid entry whose word index equals addr[ADDR_W-1:2], else mem_rd_data.
  - Comparison ignores addr[1:0]; stores are full-word only.
  - The entry being popped this cycle is still valid for forwarding.
  - The store being pushed this cycle is not visible until the next cycle.
- Youngest match: search from tail-1 backward to head.
  - Entry valid when its age offset (index-head) mod DEPTH < count.
- Latency:
  - Store visible to forwarding: 1 cycle after push.
  - Earliest memory write: the cycle after push (mem_wr_valid high), with zero wait states.
- Storage: all state in flops. No combinational path from mem_wr_ready to stall or read_data.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1, no stimulus -> count=0, empty=1, mem_wr_valid=0, stall=0, read_data==mem_rd_data.
- Store 0xAAAA0001 at 0x100, mem_wr_ready=1 -> next cycle mem_wr_valid=1, mem_wr_addr=0x100, mem_wr_data=0xAAAA0001; popped that cycle; count returns to 0.
- mem_wr_ready=0; stores to 0x10, 0x14, 0x10 (data 1, 2, 3), then load 0x12 -> read_data=3 (youngest, byte bits ignored). Load 0x18 -> read_data=mem_rd_data.
- mem_wr_ready=0; 4 stores fill the FIFO; 5th store asserted -> stall=1, count=4. Raise ready for one cycle while 5th still asserted -> pop occurs, store not accepted, count=3. Next cycle store accepted, stall=0. Drain order matches push order, pointers wrap correctly.
- Steady push every cycle with ready=1 for 10 cycles -> count stays at 1, no stall, memory sees 10 writes in order.
- Buffer 3 entries with ready=0, assert rst=0 for one cycle -> count=0, mem_wr_valid=0 next cycle. Subsequent load of a previously buffered address returns mem_rd_data.
